// File: rtl/relay_mode_ctrl.sv
// rtl/relay_mode_ctrl.sv - ISO14443-A relay link sampler, frame marker detector and mod_type sequencer
module relay_mode_ctrl #(
    parameter logic [3:0]  DIV_PHASE      = 4'd8,
    parameter logic [15:0] MAX_FRAME_BITS = 16'd4096
) (
    input  logic       ck_1356meg,
    input  logic       rst,
    input  logic [2:0] hi_simulate_mod_type,
    input  logic       relay_din,
    output logic [2:0] mod_type,
    output logic       bit_strobe,
    output logic       rx_bit,
    output logic       frame_active,
    output logic       frame_err
);

    localparam logic [2:0] FAKE_READER   = 3'b101;
    localparam logic [2:0] FAKE_TAG      = 3'b110;
    localparam logic [2:0] TAGSIM_LISTEN = 3'b001;
    localparam logic [2:0] TAGSIM_MOD    = 3'b010;
    localparam logic [2:0] READER_LISTEN = 3'b011;
    localparam logic [2:0] READER_MOD    = 3'b100;

    typedef enum logic {LISTEN = 1'b0, ACTIVE = 1'b1} state_t;

    state_t      state, state_next;
    logic [3:0]  div_counter;
    logic [31:0] shift_reg, shift_nxt;
    logic [2:0]  bit_cnt;
    logic [15:0] frame_bits;
    logic [2:0]  mode_q;
    logic        in_reset;
    logic        relay_en, is_reader, mode_switch;
    logic        start_hit, end_hit, timeout_hit, restart, err_next;

    assign relay_en    = (hi_simulate_mod_type == FAKE_READER) | (hi_simulate_mod_type == FAKE_TAG);
    assign is_reader   = (hi_simulate_mod_type == FAKE_READER);
    assign mode_switch = relay_en & (hi_simulate_mod_type != mode_q);

    always_ff @(posedge ck_1356meg) begin
        if (rst) begin
            state <= LISTEN;
        end else begin
            state <= state_next;
        end
    end

    // Markers are matched on the post-shift word so the transition lands on the sampling edge.
    always_comb begin
        shift_nxt   = {shift_reg[30:0], relay_din};
        start_hit   = is_reader ? (shift_nxt[23:0] == 24'h0000C0) : (shift_nxt[23:0] == 24'h0000F0);
        end_hit     = (bit_cnt == 3'd7) &&
                      (is_reader ? ((shift_nxt == 32'h0000_0000) || (shift_nxt == 32'hC000_0000))
                                 : (shift_nxt[23:0] == 24'h000000));
        timeout_hit = (frame_bits == MAX_FRAME_BITS - 16'd1);
        state_next  = state;
        restart     = 1'b0;
        err_next    = 1'b0;
        if (!relay_en || mode_switch) begin
            state_next = LISTEN;
        end else if (bit_strobe) begin
            case (state)
                LISTEN: begin
                    if (start_hit) begin
                        state_next = ACTIVE;
                        restart    = 1'b1;
                    end
                end
                ACTIVE: begin
                    if (end_hit) begin
                        state_next = LISTEN;
                    end else if (start_hit) begin
                        restart = 1'b1;
                    end else if (timeout_hit) begin
                        state_next = LISTEN;
                        err_next   = 1'b1;
                    end
                end
                default: state_next = LISTEN;
            endcase
        end
    end

    always_ff @(posedge ck_1356meg) begin
        if (rst) begin
            div_counter <= 4'd0;
            shift_reg   <= 32'd0;
            bit_cnt     <= 3'd0;
            frame_bits  <= 16'd0;
            bit_strobe  <= 1'b0;
            frame_err   <= 1'b0;
            mode_q      <= hi_simulate_mod_type;
            in_reset    <= 1'b1;
        end else begin
            div_counter <= div_counter + 4'd1;
            bit_strobe  <= relay_en && (div_counter == DIV_PHASE);
            frame_err   <= err_next;
            mode_q      <= hi_simulate_mod_type;
            in_reset    <= 1'b0;
            if (!relay_en || mode_switch) begin
                shift_reg <= 32'd0;
                bit_cnt   <= 3'd0;
            end else if (bit_strobe) begin
                shift_reg <= shift_nxt;
                bit_cnt   <= restart ? 3'd0 : bit_cnt + 3'd1;
                if (restart) begin
                    frame_bits <= 16'd0;
                end else if (state == ACTIVE && frame_bits != 16'hFFFF) begin
                    frame_bits <= frame_bits + 16'd1;
                end
            end
        end
    end

    always_comb begin
        mod_type     = hi_simulate_mod_type;
        rx_bit       = relay_en & shift_reg[15];
        frame_active = (state == ACTIVE);
        if (!in_reset && relay_en) begin
            if (is_reader) begin
                mod_type = (state == ACTIVE) ? READER_MOD : READER_LISTEN;
            end else begin
                mod_type = (state == ACTIVE) ? TAGSIM_MOD : TAGSIM_LISTEN;
            end
        end
    end

endmodule

// File: tb/tb_relay_mode_ctrl.sv
// tb/tb_relay_mode_ctrl.sv - self-checking bench for relay_mode_ctrl against a bit-history reference model
module tb_relay_mode_ctrl;

    localparam int MODEL_MAX = 4096;

    logic       ck;
    logic       rst;
    logic [2:0] hi_simulate_mod_type;
    logic       relay_din;
    logic [2:0] mod_type, to_mod_type;
    logic       bit_strobe, to_bit_strobe;
    logic       rx_bit, to_rx_bit;
    logic       frame_active, to_frame_active;
    logic       frame_err, to_frame_err;

    int checks = 0;
    int errors = 0;

    relay_mode_ctrl dut (
        .ck_1356meg          (ck),
        .rst                 (rst),
        .hi_simulate_mod_type(hi_simulate_mod_type),
        .relay_din           (relay_din),
        .mod_type            (mod_type),
        .bit_strobe          (bit_strobe),
        .rx_bit              (rx_bit),
        .frame_active        (frame_active),
        .frame_err           (frame_err)
    );

    relay_mode_ctrl #(.MAX_FRAME_BITS(16'd64)) dut_to (
        .ck_1356meg          (ck),
        .rst                 (rst),
        .hi_simulate_mod_type(hi_simulate_mod_type),
        .relay_din           (relay_din),
        .mod_type            (to_mod_type),
        .bit_strobe          (to_bit_strobe),
        .rx_bit              (to_rx_bit),
        .frame_active        (to_frame_active),
        .frame_err           (to_frame_err)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    // Reference model: raw history of sampled bits plus "strobes since start".
    logic       m_hist[$];
    logic       m_reader;
    logic       m_active;
    int         m_k;
    logic [2:0] exp_mod;
    logic       exp_active, exp_err, exp_rx;
    logic       seq[$];

    function automatic void model_clear();
        m_hist.delete();
        m_active   = 1'b0;
        m_k        = 0;
        exp_active = 1'b0;
        exp_err    = 1'b0;
        exp_rx     = 1'b0;
        exp_mod    = m_reader ? 3'b011 : 3'b001;
    endfunction

    function automatic void model_strobe(input logic b);
        logic [31:0] w;
        logic        st, en;
        int          n;
        m_hist.push_back(b);
        if (m_hist.size() > 40) void'(m_hist.pop_front());
        n = m_hist.size();
        w = '0;
        for (int i = 0; i < 32; i++) if (n - 1 - i >= 0) w[i] = m_hist[n-1-i];
        st = m_reader ? (w[23:0] == 24'h0000C0) : (w[23:0] == 24'h0000F0);
        exp_err = 1'b0;
        if (m_active) begin
            en = (((m_k + 1) % 8) == 0) &&
                 (m_reader ? (w == 32'h0 || w == 32'hC000_0000) : (w[23:0] == 24'h0));
            if (en) m_active = 1'b0;
            else if (st) m_k = 0;
            else if (m_k == MODEL_MAX - 1) begin
                m_active = 1'b0;
                exp_err  = 1'b1;
            end else m_k++;
        end else if (st) begin
            m_active = 1'b1;
            m_k      = 0;
        end
        exp_rx     = (n >= 16) ? m_hist[n-16] : 1'b0;
        exp_active = m_active;
        exp_mod    = m_reader ? (m_active ? 3'b100 : 3'b011) : (m_active ? 3'b010 : 3'b001);
    endfunction

    task automatic add_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) seq.push_back(v[i]);
    endtask

    task automatic add_start();
        add_bits(32'h0, 16);
        add_bits(m_reader ? 32'hC0 : 32'hF0, 8);
    endtask

    function automatic logic [7:0] rand_data();
        logic [7:0] v;
        v = 8'(($urandom_range(1, 255)));
        while (v == 8'hC0 || v == 8'hF0) v = 8'(($urandom_range(1, 255)));
        return v;
    endfunction

    // Called at a negedge; presents b, waits for the strobe, returns at the negedge after the sampling edge.
    task automatic send_bit(input logic b);
        int n = 0;
        relay_din = b;
        while (bit_strobe !== 1'b1 && n < 40) begin
            @(negedge ck);
            n++;
        end
        if (bit_strobe !== 1'b1) begin
            errors++;
            $display("FAIL strobe_wait: bit_strobe=%b after %0d cycles, required 1", bit_strobe, n);
        end
        @(posedge ck);
        #1;
        model_strobe(b);
        @(negedge ck);
        #0;
    endtask

    task automatic do_reset(input logic [2:0] mode);
        @(negedge ck);
        hi_simulate_mod_type = mode;
        relay_din            = 1'b0;
        rst                  = 1'b1;
        @(posedge ck);
        @(posedge ck);
        #1;
        checks++;
        if ({mod_type, bit_strobe, rx_bit, frame_active, frame_err} !== {mode, 4'b0000}) begin
            errors++;
            $display("FAIL reset_state: got %b required %b",
                     {mod_type, bit_strobe, rx_bit, frame_active, frame_err}, {mode, 4'b0000});
        end
        @(negedge ck);
        rst      = 1'b0;
        m_reader = (mode == 3'b101);
        model_clear();
    endtask

    task automatic test_reset();
        do_reset(3'b101);
        do_reset(3'b000);
    endtask

    task automatic test_passthrough();
        do_reset(3'b000);
        for (int m = 0; m < 5; m++) begin
            hi_simulate_mod_type = 3'(m);
            for (int c = 0; c < 40; c++) begin
                @(posedge ck);
                #1;
                checks++;
                if ({mod_type, bit_strobe, rx_bit} !== {3'(m), 2'b00}) begin
                    errors++;
                    $display("FAIL passthrough mode %0d: got %b required %b", m,
                             {mod_type, bit_strobe, rx_bit}, {3'(m), 2'b00});
                end
                @(negedge ck);
            end
        end
    endtask

    task automatic test_reader_start();
        do_reset(3'b101);
        seq.delete();
        add_start();
        foreach (seq[i]) begin
            send_bit(seq[i]);
            checks++;
            if ({mod_type, frame_active, frame_err, rx_bit} !== {exp_mod, exp_active, exp_err, exp_rx}) begin
                errors++;
                $display("FAIL reader_start bit %0d: got %b required %b", i,
                         {mod_type, frame_active, frame_err, rx_bit}, {exp_mod, exp_active, exp_err, exp_rx});
            end
            if (i == seq.size() - 2) begin
                checks++;
                if ({mod_type, frame_active} !== {3'b011, 1'b0}) begin
                    errors++;
                    $display("FAIL reader_before_marker: got %b required 0110", {mod_type, frame_active});
                end
            end
        end
        checks++;
        if ({mod_type, frame_active} !== {3'b100, 1'b1}) begin
            errors++;
            $display("FAIL reader_start_marker: got %b required 1001", {mod_type, frame_active});
        end
    endtask

    // kind 0: 32 zeros, 1: C000_0000, 2: one stray bit then 32 zeros (misaligned)
    task automatic test_reader_end(input int kind);
        seq.delete();
        if (kind != 0) add_start();
        for (int b = 0; b < 8; b++) add_bits(32'(rand_data()), 8);
        if (kind == 2) add_bits(32'h1, 1);
        add_bits(kind == 1 ? 32'hC000_0000 : 32'h0, 32);
        foreach (seq[i]) begin
            send_bit(seq[i]);
            checks++;
            if ({mod_type, frame_active, frame_err, rx_bit} !== {exp_mod, exp_active, exp_err, exp_rx}) begin
                errors++;
                $display("FAIL reader_end%0d bit %0d: got %b required %b", kind, i,
                         {mod_type, frame_active, frame_err, rx_bit}, {exp_mod, exp_active, exp_err, exp_rx});
            end
            if (i == seq.size() - 2) begin
                checks++;
                if (mod_type !== 3'b100) begin
                    errors++;
                    $display("FAIL reader_end%0d_early: got %b required 100", kind, mod_type);
                end
            end
        end
        checks++;
        if (mod_type !== ((kind == 2) ? 3'b100 : 3'b011)) begin
            errors++;
            $display("FAIL reader_end%0d_final: got %b required %b", kind, mod_type,
                     (kind == 2) ? 3'b100 : 3'b011);
        end
    endtask

    task automatic test_tag_frame();
        int n = 0;
        int per = 1;
        do_reset(3'b110);
        while (bit_strobe !== 1'b1 && n < 40) begin
            @(negedge ck);
            n++;
        end
        @(negedge ck);
        while (bit_strobe !== 1'b1 && per < 40) begin
            @(negedge ck);
            per++;
        end
        checks++;
        if (per != 16) begin
            errors++;
            $display("FAIL strobe_period: got %0d clocks required 16", per);
        end
        do_reset(3'b110);
        seq.delete();
        add_start();
        add_bits(32'h0, 24);
        foreach (seq[i]) begin
            send_bit(seq[i]);
            checks++;
            if ({mod_type, frame_active, frame_err, rx_bit} !== {exp_mod, exp_active, exp_err, exp_rx}) begin
                errors++;
                $display("FAIL tag_frame bit %0d: got %b required %b", i,
                         {mod_type, frame_active, frame_err, rx_bit}, {exp_mod, exp_active, exp_err, exp_rx});
            end
            if (i == 23 || i == seq.size() - 2 || i == seq.size() - 1) begin
                checks++;
                if (mod_type !== ((i == seq.size() - 1) ? 3'b001 : 3'b010)) begin
                    errors++;
                    $display("FAIL tag_mod bit %0d: got %b required %b", i, mod_type,
                             (i == seq.size() - 1) ? 3'b001 : 3'b010);
                end
            end
        end
    endtask

    task automatic test_timeout();
        int j;
        do_reset(3'b101);
        seq.delete();
        add_start();
        add_bits(32'hFFFF_FFFF, 32);
        add_bits(32'hFFFF_FFFF, 32);
        add_bits(32'hFF, 6);
        foreach (seq[i]) begin
            send_bit(seq[i]);
            j = i - 23;
            checks++;
            if ({to_mod_type, to_frame_active, to_frame_err} !==
                {(j >= 0 && j < 64) ? 3'b100 : 3'b011, (j >= 0 && j < 64), (j == 64)}) begin
                errors++;
                $display("FAIL timeout strobe %0d: got %b required %b", j,
                         {to_mod_type, to_frame_active, to_frame_err},
                         {(j >= 0 && j < 64) ? 3'b100 : 3'b011, (j >= 0 && j < 64), (j == 64)});
            end
            checks++;
            if ({frame_active, frame_err} !== {exp_active, exp_err}) begin
                errors++;
                $display("FAIL long_frame strobe %0d: got %b required %b", j,
                         {frame_active, frame_err}, {exp_active, exp_err});
            end
            if (j == 64) begin
                @(posedge ck);
                #1;
                checks++;
                if (to_frame_err !== 1'b0) begin
                    errors++;
                    $display("FAIL timeout_pulse_width: got %b required 0", to_frame_err);
                end
                @(negedge ck);
            end
        end
    endtask

    task automatic test_abort();
        for (int a = 0; a < 3; a++) begin
            do_reset(3'b101);
            seq.delete();
            add_start();
            add_bits(32'hFFFF, 16);
            foreach (seq[i]) begin
                send_bit(seq[i]);
                checks++;
                if ({mod_type, frame_active, frame_err, rx_bit} !== {exp_mod, exp_active, exp_err, exp_rx}) begin
                    errors++;
                    $display("FAIL abort%0d_setup bit %0d: got %b required %b", a, i,
                             {mod_type, frame_active, frame_err, rx_bit}, {exp_mod, exp_active, exp_err, exp_rx});
                end
            end
            if (a == 0) rst = 1'b1;
            else hi_simulate_mod_type = (a == 1) ? 3'b000 : 3'b110;
            @(posedge ck);
            #1;
            checks++;
            if ({mod_type, frame_active, frame_err, rx_bit} !==
                {(a == 0) ? 3'b101 : (a == 1) ? 3'b000 : 3'b001, 3'b000}) begin
                errors++;
                $display("FAIL abort%0d: got %b required %b", a, {mod_type, frame_active, frame_err, rx_bit},
                         {(a == 0) ? 3'b101 : (a == 1) ? 3'b000 : 3'b001, 3'b000});
            end
            @(negedge ck);
            rst = 1'b0;
            for (int c = 0; c < 20; c++) begin
                @(posedge ck);
                #1;
                checks++;
                if ({frame_err, frame_active} !== 2'b00) begin
                    errors++;
                    $display("FAIL abort%0d_quiet cycle %0d: got %b required 00", a, c, {frame_err, frame_active});
                end
            end
            @(negedge ck);
        end
    endtask

    task automatic test_random(input logic [2:0] mode);
        do_reset(mode);
        seq.delete();
        while (seq.size() < 500) begin
            case ($urandom_range(0, 5))
                0:       add_start();
                1:       add_bits(32'h0, int'($urandom_range(20, 32)));
                2:       add_bits(32'hC000_0000, 32);
                default: add_bits(32'($urandom_range(0, 255)), 8);
            endcase
        end
        foreach (seq[i]) begin
            send_bit(seq[i]);
            checks++;
            if ({mod_type, frame_active, frame_err, rx_bit} !== {exp_mod, exp_active, exp_err, exp_rx}) begin
                errors++;
                $display("FAIL random_%b bit %0d: got %b required %b", mode, i,
                         {mod_type, frame_active, frame_err, rx_bit}, {exp_mod, exp_active, exp_err, exp_rx});
            end
        end
    endtask

    initial begin
        rst                  = 1'b1;
        hi_simulate_mod_type = 3'b000;
        relay_din            = 1'b0;
        m_reader             = 1'b0;
        model_clear();
        test_reset();
        test_passthrough();
        test_reader_start();
        test_reader_end(0);
        test_reader_end(1);
        test_reader_end(2);
        test_tag_frame();
        test_timeout();
        test_abort();
        test_random(3'b101);
        test_random(3'b110);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
